// File: rtl/maxpool2x2.sv
// 2x2, stride-2 max pooling over an image held in a combinational-read frame
// memory. Each pooled pixel takes four read cycles plus one write cycle. The
// start/ready handshake matches conv2d, so the two blocks can be chained.
module maxpool2x2 #(
  parameter int IMG_W    = 50,
  parameter int IMG_H    = 50,
  parameter int DW       = 12,
  parameter int AW       = 17,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] d_in,
  output logic [AW-1:0] ReadAddress,
  output logic [AW-1:0] WriteAddress,
  output logic [DW-1:0] d_out,
  output logic          ready,
  output logic          WriteEnable
);

  // Odd trailing columns/rows are dropped by the truncating divide.
  localparam int OW = IMG_W / 2;
  localparam int OH = IMG_H / 2;
  localparam int CW = 16;

  localparam logic [AW-1:0] IN_BASE_A  = AW'(IN_BASE);
  localparam logic [AW-1:0] OUT_BASE_A = AW'(OUT_BASE);
  localparam logic [AW-1:0] OFF_ROW    = AW'(IMG_W);
  localparam logic [AW-1:0] OFF_ROW1   = AW'(IMG_W + 1);
  localparam logic [AW-1:0] STEP_ROW   = AW'(2 * IMG_W);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t        state;
  logic [1:0]    k;
  logic [CW-1:0] ox;
  logic [CW-1:0] oy;
  logic [AW-1:0] row_base;
  logic [AW-1:0] win_base;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] acc;
  logic          last_col;
  logic          last_row;

  // Unsigned compare; equal values simply return that value.
  function automatic logic [DW-1:0] pix_max(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign last_col = (ox == CW'(OW - 1));
  assign last_row = (oy == CW'(OH - 1));

  // Control FSM with registered memory-side outputs; window and output
  // addresses advance incrementally so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= 2'd0;
      ox           <= '0;
      oy           <= '0;
      row_base     <= IN_BASE_A;
      win_base     <= IN_BASE_A;
      out_addr     <= OUT_BASE_A;
      acc          <= '0;
      ReadAddress  <= IN_BASE_A;
      WriteAddress <= OUT_BASE_A;
      d_out        <= '0;
      WriteEnable  <= 1'b0;
      ready        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          WriteEnable <= 1'b0;
          if (start) begin
            state       <= RD;
            k           <= 2'd0;
            ox          <= '0;
            oy          <= '0;
            row_base    <= IN_BASE_A;
            win_base    <= IN_BASE_A;
            out_addr    <= OUT_BASE_A;
            ReadAddress <= IN_BASE_A;
            ready       <= 1'b0;
          end
        end
        RD: begin
          acc <= (k == 2'd0) ? d_in : pix_max(acc, d_in);
          k   <= k + 2'd1;
          // Present the next window pixel: +1, +IMG_W, +IMG_W+1 from the base.
          case (k)
            2'd0:    ReadAddress <= win_base + AW'(1);
            2'd1:    ReadAddress <= win_base + OFF_ROW;
            2'd2:    ReadAddress <= win_base + OFF_ROW1;
            default: ReadAddress <= ReadAddress;
          endcase
          if (k == 2'd3) begin
            state        <= WR;
            WriteEnable  <= 1'b1;
            WriteAddress <= out_addr;
            d_out        <= pix_max(acc, d_in);
          end
        end
        WR: begin
          WriteEnable <= 1'b0;
          out_addr    <= out_addr + AW'(1);
          k           <= 2'd0;
          if (last_col && last_row) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            state <= RD;
            if (last_col) begin
              ox          <= '0;
              oy          <= oy + CW'(1);
              row_base    <= row_base + STEP_ROW;
              win_base    <= row_base + STEP_ROW;
              ReadAddress <= row_base + STEP_ROW;
            end else begin
              ox          <= ox + CW'(1);
              win_base    <= win_base + AW'(2);
              ReadAddress <= win_base + AW'(2);
            end
          end
        end
        default: begin
          state       <= IDLE;
          WriteEnable <= 1'b0;
          ready       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2x2.sv
// Bench for maxpool2x2: four instances with different geometries/bases, each
// backed by its own combinational frame memory. A window-max reference model
// computed directly from the memory contents supplies every expected pixel.
module tb_maxpool2x2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st   [4];
  logic [11:0] din  [4];
  logic [16:0] ra   [4];
  logic [16:0] wa   [4];
  logic [11:0] dout [4];
  logic        rdy  [4];
  logic        we   [4];

  logic [11:0] mem [4][4096];
  logic [11:0] got [1024];

  int total = 0;
  int bad   = 0;
  int IBS [4] = '{0, 0, 0, 2500};
  int OBS [4] = '{0, 0, 0, 1000};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_rd
    assign din[g] = mem[g][ra[g][11:0]];
  end

  maxpool2x2 u0 (
    .clk(clk), .rst(rst), .start(st[0]), .d_in(din[0]), .ReadAddress(ra[0]),
    .WriteAddress(wa[0]), .d_out(dout[0]), .ready(rdy[0]), .WriteEnable(we[0]));

  maxpool2x2 #(.IMG_W(4), .IMG_H(4)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .d_in(din[1]), .ReadAddress(ra[1]),
    .WriteAddress(wa[1]), .d_out(dout[1]), .ready(rdy[1]), .WriteEnable(we[1]));

  maxpool2x2 #(.IMG_W(5), .IMG_H(5)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .d_in(din[2]), .ReadAddress(ra[2]),
    .WriteAddress(wa[2]), .d_out(dout[2]), .ready(rdy[2]), .WriteEnable(we[2]));

  maxpool2x2 #(.IMG_W(4), .IMG_H(4), .IN_BASE(2500), .OUT_BASE(1000)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .d_in(din[3]), .ReadAddress(ra[3]),
    .WriteAddress(wa[3]), .d_out(dout[3]), .ready(rdy[3]), .WriteEnable(we[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Max of the 2x2 window at output (ox,oy), straight from the memory image.
  function automatic logic [11:0] ref_px(int g, int w, int ib, int ox, int oy);
    int b;
    int offs [4];
    logic [11:0] m;
    b    = ib + (2 * oy) * w + 2 * ox;
    offs = '{0, 1, w, w + 1};
    m    = 12'd0;
    foreach (offs[j])
      if (mem[g][12'(b + offs[j])] > m) m = mem[g][12'(b + offs[j])];
    return m;
  endfunction

  function automatic logic [11:0] rnd_px();
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? 12'd4095 : 12'd0;
    return 12'($urandom_range(0, 4095));
  endfunction

  task automatic fill_rand(input int g);
    for (int i = 0; i < 4096; i++) mem[g][i] = rnd_px();
  endtask

  // One pass: optional busy start at cycle 'poke', optional reset at 'rst_at'.
  task automatic run_pass(input int g, input int w, input int h, input int ib,
                          input int ob, input int poke, input int rst_at);
    int ow, oh, n, nw, cyc, bad_rd, a;
    bit done_rst;
    ow = w / 2; oh = h / 2; n = ow * oh;
    nw = 0; bad_rd = 0; done_rst = 1'b0;
    @(negedge clk); st[g] = 1'b1;
    @(negedge clk); st[g] = 1'b0; cyc = 1;
    chk("first_read_addr", 32'(ra[g]), ib);
    chk("ready_low_busy", 32'(rdy[g]), 0);
    while (!rdy[g] && cyc <= 5 * n + 10 && !done_rst) begin
      if (we[g]) begin
        if (nw < n) begin
          chk("wr_addr", 32'(wa[g]), ob + nw);
          chk("wr_data", 32'(dout[g]), 32'(ref_px(g, w, ib, nw % ow, nw / ow)));
          chk("wr_cycle", cyc, 5 * (nw + 1));
          got[nw] = dout[g];
        end
        nw++;
      end
      a = int'(ra[g]);
      if (g == 2 && (a % 5 == 4 || a >= 20)) bad_rd++;
      st[g] = (cyc == poke);
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_we", 32'(we[g]), 0);
        chk("rst_ready", 32'(rdy[g]), 1);
        chk("rst_raddr", 32'(ra[g]), ib);
        chk("rst_waddr", 32'(wa[g]), ob);
        chk("rst_dout", 32'(dout[g]), 0);
        done_rst = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    st[g] = 1'b0;
    if (done_rst) begin
      chk("writes_before_rst", nw, rst_at / 5);
      for (int i = 0; i < 20; i++) begin
        if (we[g]) nw++;
        @(negedge clk);
      end
      chk("no_writes_after_rst", nw, rst_at / 5);
    end else begin
      chk("ready_cycle", cyc, 5 * n + 1);
      chk("write_count", nw, n);
      if (g == 2) chk("odd_edge_unread", bad_rd, 0);
    end
  endtask

  initial begin
    int d44 [16];
    for (int g = 0; g < 4; g++) st[g] = 1'b0;
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 4096; i++) mem[g][i] = 12'd0;

    // Reset state of every instance.
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("reset_raddr", 32'(ra[g]), IBS[g]);
      chk("reset_waddr", 32'(wa[g]), OBS[g]);
      chk("reset_dout", 32'(dout[g]), 0);
      chk("reset_we", 32'(we[g]), 0);
      chk("reset_ready", 32'(rdy[g]), 1);
    end
    rst = 1'b0;

    // Default geometry, ramp image.
    for (int i = 0; i < 4096; i++) mem[0][i] = 12'(i % 4096);
    run_pass(0, 50, 50, 0, 0, 0, 0);
    chk("big_out0", 32'(got[0]), 51);
    chk("big_out624", 32'(got[624]), 2499);

    // 4x4 directed image, including the 4095 extreme.
    d44 = '{1, 9, 2, 2, 3, 4, 8, 0, 0, 0, 4095, 7, 5, 1, 6, 4095};
    for (int i = 0; i < 16; i++) mem[1][i] = 12'(d44[i]);
    run_pass(1, 4, 4, 0, 0, 0, 0);
    chk("sq_out0", 32'(got[0]), 9);
    chk("sq_out1", 32'(got[1]), 8);
    chk("sq_out2", 32'(got[2]), 5);
    chk("sq_out3", 32'(got[3]), 4095);

    // Start pulsed while busy must be ignored.
    fill_rand(1);
    run_pass(1, 4, 4, 0, 0, 7, 0);

    // Reset mid-pass, then a fresh complete pass.
    fill_rand(1);
    run_pass(1, 4, 4, 0, 0, 0, 12);
    run_pass(1, 4, 4, 0, 0, 0, 0);

    // 5x5: last column/row are bright but must never be read.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        mem[2][r * 5 + c] = (c == 4 || r == 4) ? 12'd4095 : 12'd0;
    run_pass(2, 5, 5, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk("odd_out_zero", 32'(got[i]), 0);
    fill_rand(2);
    run_pass(2, 5, 5, 0, 0, 0, 0);

    // Non-zero read/write bases.
    fill_rand(3);
    run_pass(3, 4, 4, 2500, 1000, 0, 0);

    // Random full-size image.
    fill_rand(0);
    run_pass(0, 50, 50, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
